lpf_stage_sequencer: RTL and testbench
======================================

Name: lpf_stage_sequencer

Overview:
- Sample-rate scheduler for the 3-pole one-pole-cascade output low-pass filter.
- Runs all three filter stages through one shared 16x16 signed multiplier, one stage per clock, replacing three parallel multipliers.
- Owns the stage state registers and a run-time-writable coefficient bank.
- Sits between the SID voice mixer output (16-bit signed at clkEn rate) and the audio output serializer.

Parameters:
- C0_INIT, 16'h099b, stage-0 coefficient reset value (Q1.15, about 15 kHz).
- C1_INIT, 16'h0a86, stage-1 coefficient reset value (about 17.5 kHz).
- C2_INIT, 16'h0b6e, stage-2 coefficient reset value (about 20 kHz).

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- clkEn  in  1  sample strobe, one-cycle pulse.
- iIn  in  16  signed input sample, valid when clkEn=1.
- iCoefWe  in  1  coefficient write strobe.
- iCoefAddr  in  2  coefficient index 0..2; index 3 is ignored.
- iCoefData  in  16  signed coefficient value.
- iClrOverrun  in  1  clears oOverrun.
- oOut  out  16  signed filtered sample.
- oValid  out  1  one-cycle pulse when oOut updates.
- oBusy  out  1  high while the FSM is not IDLE.
- oOverrun  out  1  sticky flag: a sample was dropped.

Behaviour:
- One clock domain; reset is synchronous and active-low on rstn.
- Reset values:
  - FSM to IDLE.
  - s0, s1, s2, oOut = 0.
  - oValid = 0, oOverrun = 0.
  - Coefficient bank and shadow copies = C*_INIT.
- FSM states: IDLE -> ST0 -> ST1 -> ST2 -> IDLE, one cycle per state.
- IDLE with clkEn=1: latch x <= iIn, copy the coefficient bank into shadow registers, go to ST0.
- Stage k (ST0/ST1/ST2):
  - a = x, s0, s1 respectively; b = s_k.
  - d = a - b, 17-bit signed.
  - p = c_k * d, 33-bit signed, from the single shared multiplier.
  - inc = p >>> 15, arithmetic shift (floor), taken as 18 bits.
  - s_k <= limit16(s_k + inc).
- Stages are strictly sequential: ST1 uses s0 as updated in ST0, and ST2 uses s1 as updated in ST1.
- ST2 also loads oOut with the new s2 (same cycle as the s2 update) and asserts oValid for one cycle.
- Latency: clkEn at cycle N -> oValid and new oOut at cycle N+4 (registered outputs).
- oBusy = 1 in ST0..ST2.
- clkEn while oBusy=1: the sample is dropped, the in-flight computation is unaffected, and oOverrun is set.
- clkEn in the same cycle the FSM returns to IDLE (the cycle after ST2) is accepted normally.
- oOverrun: clear has priority over set in the same cycle.
- Coefficient writes:
  - Update the bank immediately.
  - Affect the next accepted sample only, never an in-flight one, because shadows are copied at acceptance.
  - A write coinciding with acceptance is not seen by that sample.
- rstn low mid-computation: abort immediately, all state to reset values, no oValid.
- limit16: saturate to [-32768, 32767] or wrap; selected by LPF_SEQ_SATURATE_EN.

Optional Feature:
- Macro: LPF_SEQ_SATURATE_EN.
- Defined: limit16 saturates, so overflow above 32767 clamps to 32767 and below -32768 clamps to -32768.
- Undefined: limit16 keeps the low 16 bits (two's-complement wrap); no saturation logic is generated.
- With coefficients in [0, 0x7FFF] no overflow occurs either way; only negative coefficients can overflow.

Decomposition:
- Shared package lpf_pkg holds:
  - FSM state enum (IDLE, ST0, ST1, ST2).
  - Widths: sample 16, diff 17, product 33, increment 18.
  - Default coefficient constants 16'h099b, 16'h0a86, 16'h0b6e.
- One natural sub-module: lpf_mac_step, a combinational d/multiply/shift/limit unit instantiated once and muxed by state.
- The macro is tested inside lpf_mac_step.

Test Plan:
- Step response: reset, then clkEn with iIn=16'h4000 -> after 4 cycles oValid=1, s0=16'h04CD, s1=16'h0065, oOut=16'h0009.
- Overrun: clkEn at cycles N and N+2 -> second sample dropped, oOverrun=1, exactly one oValid at N+4; iClrOverrun -> 0; clear and set in the same cycle -> stays 0.
- Coefficient shadowing:
  - Write addr 0 = 16'h0000 at cycle N+1 of a computation -> that result is unchanged.
  - Next sample with iIn=16'h4000 from reset state -> s0 holds, oOut=0.
  - Write to addr 3 -> no effect.
- Overflow, after writing c0=16'h8000 with iIn=16'h7FFF twice:
  - First sample -> s0=-32767.
  - Second sample, saturating build -> s0=-32768.
  - Second sample, wrapping build -> s0=16'h8003.
- Reset mid-operation: rstn=0 at cycle N+2 -> no oValid, oOut=0, oBusy=0, coefficients back to C*_INIT.
- Back-to-back: clkEn at N and N+4 -> both accepted, oValid at N+4 and N+8, oOverrun=0.

Source files
------------

// File: rtl/lpf_pkg.sv
// Shared types and constants for the low-pass stage sequencer.
package lpf_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int DIFF_W     = 17;
    localparam int PROD_W     = 33;
    localparam int INC_W      = 18;
    localparam int NUM_STAGES = 3;
    localparam int FRAC_W     = 15;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef sample_t coef_bank_t [NUM_STAGES];

    localparam sample_t C0_DEFAULT = 16'sh099b;
    localparam sample_t C1_DEFAULT = 16'sh0a86;
    localparam sample_t C2_DEFAULT = 16'sh0b6e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ST0  = 2'd1,
        ST1  = 2'd2,
        ST2  = 2'd3
    } lpf_state_e;

endpackage

// File: rtl/lpf_stage_sequencer_mac_step.sv
// One filter stage: s_o = limit16(b + (coef * (a - b)) >>> 15).
// LPF_SEQ_SATURATE_EN selects saturating limit16; otherwise the result wraps.
module lpf_mac_step
    import lpf_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0] a_i,
    input  logic signed [SAMPLE_W-1:0] b_i,
    input  logic signed [SAMPLE_W-1:0] coef_i,
    output logic signed [SAMPLE_W-1:0] s_o
);

    logic signed [DIFF_W-1:0]  diff;
    logic signed [PROD_W-1:0]  coef_x;
    logic signed [PROD_W-1:0]  diff_x;
    logic signed [PROD_W-1:0]  prod;
    logic signed [INC_W-1:0]   inc;
    logic signed [INC_W:0]     sum;

    // Fractional product bits fall below the Q1.15 point and are discarded by design.
    logic unused_lsbs;

    always_comb begin
        diff   = {a_i[SAMPLE_W-1], a_i} - {b_i[SAMPLE_W-1], b_i};
        coef_x = {{(PROD_W-SAMPLE_W){coef_i[SAMPLE_W-1]}}, coef_i};
        diff_x = {{(PROD_W-DIFF_W){diff[DIFF_W-1]}}, diff};
        prod   = coef_x * diff_x;
        // Slicing the top bits is the floor (arithmetic) shift by FRAC_W.
        inc    = prod[PROD_W-1:FRAC_W];
        sum    = {inc[INC_W-1], inc} + {{(INC_W+1-SAMPLE_W){b_i[SAMPLE_W-1]}}, b_i};
    end

`ifdef LPF_SEQ_SATURATE_EN
    localparam logic signed [INC_W:0] SUM_MAX = 19'sd32767;
    localparam logic signed [INC_W:0] SUM_MIN = -19'sd32768;

    always_comb begin
        if (sum > SUM_MAX) begin
            s_o = 16'sh7fff;
        end else if (sum < SUM_MIN) begin
            s_o = 16'sh8000;
        end else begin
            s_o = sum[SAMPLE_W-1:0];
        end
    end

    assign unused_lsbs = ^prod[FRAC_W-1:0];
`else
    assign s_o         = sum[SAMPLE_W-1:0];
    assign unused_lsbs = ^{prod[FRAC_W-1:0], sum[INC_W:SAMPLE_W]};
`endif

endmodule

// File: rtl/lpf_stage_sequencer.sv
// Sample-rate scheduler for a 3-pole one-pole cascade, one stage per clock on a shared multiplier.
// Define LPF_SEQ_SATURATE_EN to saturate stage results (handled inside lpf_mac_step).
module lpf_stage_sequencer
    import lpf_pkg::*;
#(
    parameter logic signed [SAMPLE_W-1:0] C0_INIT = C0_DEFAULT,
    parameter logic signed [SAMPLE_W-1:0] C1_INIT = C1_DEFAULT,
    parameter logic signed [SAMPLE_W-1:0] C2_INIT = C2_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       clkEn,
    input  logic signed [SAMPLE_W-1:0] iIn,
    input  logic                       iCoefWe,
    input  logic [1:0]                 iCoefAddr,
    input  logic signed [SAMPLE_W-1:0] iCoefData,
    input  logic                       iClrOverrun,
    output logic signed [SAMPLE_W-1:0] oOut,
    output logic                       oValid,
    output logic                       oBusy,
    output logic                       oOverrun
);

    lpf_state_e state_q, state_d;
    sample_t    x_q, x_d;
    sample_t    s0_q, s0_d;
    sample_t    s1_q, s1_d;
    sample_t    s2_q, s2_d;
    sample_t    out_q, out_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;
    coef_bank_t coef_q, coef_d;
    coef_bank_t shadow_q, shadow_d;

    sample_t    mac_a, mac_b, mac_c, mac_s;

    // Operand mux for the single shared stage unit, selected by the active stage.
    always_comb begin
        mac_a = x_q;
        mac_b = s0_q;
        mac_c = shadow_q[0];
        case (state_q)
            ST1: begin
                mac_a = s0_q;
                mac_b = s1_q;
                mac_c = shadow_q[1];
            end
            ST2: begin
                mac_a = s1_q;
                mac_b = s2_q;
                mac_c = shadow_q[2];
            end
            default: ;
        endcase
    end

    lpf_mac_step u_mac (
        .a_i    (mac_a),
        .b_i    (mac_b),
        .coef_i (mac_c),
        .s_o    (mac_s)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        x_d       = x_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        coef_d    = coef_q;
        shadow_d  = shadow_q;

        case (state_q)
            IDLE: begin
                if (clkEn) begin
                    x_d      = iIn;
                    shadow_d = coef_q;
                    state_d  = ST0;
                end
            end
            ST0: begin
                s0_d    = mac_s;
                state_d = ST1;
            end
            ST1: begin
                s1_d    = mac_s;
                state_d = ST2;
            end
            ST2: begin
                s2_d    = mac_s;
                out_d   = mac_s;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clkEn && state_q != IDLE) begin
            overrun_d = 1'b1;
        end
        if (iClrOverrun) begin
            overrun_d = 1'b0;
        end

        // Bank writes take effect at once; an in-flight sample reads only its shadow copy.
        if (iCoefWe && iCoefAddr != 2'd3) begin
            coef_d[iCoefAddr] = iCoefData;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            x_q       <= '0;
            s0_q      <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            // NOTE: the coefficient bank is a small register file, so it can and must reset to known values.
            coef_q    <= '{C0_INIT, C1_INIT, C2_INIT};
            shadow_q  <= '{C0_INIT, C1_INIT, C2_INIT};
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            coef_q    <= coef_d;
            shadow_q  <= shadow_d;
        end
    end

    assign oOut     = out_q;
    assign oValid   = valid_q;
    assign oBusy    = (state_q != IDLE);
    assign oOverrun = overrun_q;

endmodule

// File: tb/tb_lpf_stage_sequencer.sv
// Self-checking bench for lpf_stage_sequencer against a transaction-level filter model.
module tb_lpf_stage_sequencer;

    localparam int C0 = 2459;   // 16'h099b
    localparam int C1 = 2694;   // 16'h0a86
    localparam int C2 = 2926;   // 16'h0b6e

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clkEn = 1'b0;
    logic [15:0] iIn = '0;
    logic        iCoefWe = 1'b0;
    logic [1:0]  iCoefAddr = '0;
    logic [15:0] iCoefData = '0;
    logic        iClrOverrun = 1'b0;
    logic [15:0] oOut;
    logic        oValid;
    logic        oBusy;
    logic        oOverrun;

    int checks = 0;
    int errors = 0;

    // Reference model state: accepted samples are filtered whole, results appear 3 edges later.
    int m_c [3];
    int m_s [3];
    int m_out, m_pend, m_edge, m_free, m_vedge;
    bit m_valid, m_ovr, m_busy;

    always #5 clk = ~clk;

    lpf_stage_sequencer dut (
        .clk         (clk),
        .rstn        (rstn),
        .clkEn       (clkEn),
        .iIn         (iIn),
        .iCoefWe     (iCoefWe),
        .iCoefAddr   (iCoefAddr),
        .iCoefData   (iCoefData),
        .iClrOverrun (iClrOverrun),
        .oOut        (oOut),
        .oValid      (oValid),
        .oBusy       (oBusy),
        .oOverrun    (oOverrun)
    );

    function automatic int limit16(longint v);
`ifdef LPF_SEQ_SATURATE_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
`else
        longint w;
        w = ((v % 65536) + 65536) % 65536;
        if (w >= 32768) w = w - 65536;
        return int'(w);
`endif
    endfunction

    function automatic int stage(int c, int a, int b);
        longint p, q;
        p = longint'(c) * longint'(a - b);
        q = p / 32768;
        if (p < 0 && (p % 32768) != 0) q = q - 1;
        return limit16(longint'(b) + q);
    endfunction

    task automatic model_edge();
        m_edge++;
        if (!rstn) begin
            m_s = '{0, 0, 0};
            m_c = '{C0, C1, C2};
            m_out = 0; m_valid = 0; m_ovr = 0; m_free = 0; m_vedge = -1;
        end else begin
            m_valid = (m_edge == m_vedge);
            if (m_valid) m_out = m_pend;
            if (clkEn) begin
                if (m_edge >= m_free) begin
                    m_s[0] = stage(m_c[0], int'($signed(iIn)), m_s[0]);
                    m_s[1] = stage(m_c[1], m_s[0], m_s[1]);
                    m_s[2] = stage(m_c[2], m_s[1], m_s[2]);
                    m_pend  = m_s[2];
                    m_vedge = m_edge + 3;
                    m_free  = m_edge + 4;
                end else begin
                    m_ovr = 1;
                end
            end
            if (iClrOverrun) m_ovr = 0;
            if (iCoefWe && iCoefAddr != 2'd3) m_c[iCoefAddr] = int'($signed(iCoefData));
        end
        m_busy = (m_edge < m_free - 1);
    endtask

    task automatic tick(input bit en, input logic [15:0] din, input bit we,
                        input logic [1:0] addr, input logic [15:0] data, input bit clr);
        clkEn = en; iIn = din; iCoefWe = we; iCoefAddr = addr; iCoefData = data; iClrOverrun = clr;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (oOut !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h want 0000", oOut); end
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", oValid); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", oBusy); end
        checks++; if (oOverrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", oOverrun); end
        checks++; if (dut.s0_q !== 16'h0000) begin errors++; $display("FAIL reset_s0: got %h want 0000", dut.s0_q); end
    endtask

    task automatic test_step();
        do_reset();
        tick(1'b1, 16'h4000, 1'b0, 2'd0, 16'h0, 1'b0);
        checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL step_busy: got %b want 1", oBusy); end
        idle(2);
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL step_early_valid: got %b want 0", oValid); end
        idle(1);
        checks++; if (oValid !== 1'b1) begin errors++; $display("FAIL step_valid: got %b want 1", oValid); end
        checks++; if (oOut !== 16'h0009) begin errors++; $display("FAIL step_out: got %h want 0009", oOut); end
        checks++; if (dut.s0_q !== 16'h04cd) begin errors++; $display("FAIL step_s0: got %h want 04cd", dut.s0_q); end
        checks++; if (dut.s1_q !== 16'h0065) begin errors++; $display("FAIL step_s1: got %h want 0065", dut.s1_q); end
        idle(1);
        checks++; if (oValid !== 1'b0 || oBusy !== 1'b0) begin
            errors++; $display("FAIL step_after: valid %b busy %b want 0 0", oValid, oBusy);
        end
    endtask

    task automatic test_overrun();
        int nvalid;
        do_reset();
        nvalid = 0;
        tick(1'b1, 16'($urandom), 1'b0, 2'd0, 16'h0, 1'b0);
        nvalid += int'(oValid);
        idle(1);
        nvalid += int'(oValid);
        tick(1'b1, 16'($urandom), 1'b0, 2'd0, 16'h0, 1'b0);
        nvalid += int'(oValid);
        checks++; if (oOverrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", oOverrun); end
        idle(1);
        checks++; if (oValid !== 1'b1) begin errors++; $display("FAIL overrun_valid_at_n4: got %b want 1", oValid); end
        checks++; if (int'($signed(oOut)) !== m_out) begin
            errors++; $display("FAIL overrun_out: got %0d want %0d", $signed(oOut), m_out);
        end
        for (int i = 0; i < 4; i++) begin
            idle(1);
            nvalid += int'(oValid);
        end
        checks++; if (nvalid !== 0) begin errors++; $display("FAIL overrun_extra_valid: got %0d extra pulses want 0", nvalid); end
        tick(1'b0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b1);
        checks++; if (oOverrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", oOverrun); end
        tick(1'b1, 16'h1234, 1'b0, 2'd0, 16'h0, 1'b0);
        tick(1'b1, 16'h4321, 1'b0, 2'd0, 16'h0, 1'b1);
        checks++; if (oOverrun !== 1'b0) begin errors++; $display("FAIL overrun_clr_priority: got %b want 0", oOverrun); end
        idle(4);
    endtask

    task automatic test_shadow();
        do_reset();
        tick(1'b1, 16'h4000, 1'b0, 2'd0, 16'h0, 1'b0);
        tick(1'b0, 16'h0, 1'b1, 2'd0, 16'h0000, 1'b0);
        idle(2);
        checks++; if (oValid !== 1'b1 || oOut !== 16'h0009) begin
            errors++; $display("FAIL shadow_inflight: valid %b out %h want 1 0009", oValid, oOut);
        end
        // Write coinciding with acceptance restores c0 but the sample still sees c0 = 0.
        tick(1'b1, 16'h4000, 1'b1, 2'd0, 16'h099b, 1'b0);
        idle(3);
        checks++; if (int'($signed(oOut)) !== m_out) begin
            errors++; $display("FAIL shadow_same_cycle: got %0d want %0d", $signed(oOut), m_out);
        end
        do_reset();
        tick(1'b0, 16'h0, 1'b1, 2'd0, 16'h0000, 1'b0);
        tick(1'b1, 16'h4000, 1'b0, 2'd0, 16'h0, 1'b0);
        idle(3);
        checks++; if (oOut !== 16'h0000 || dut.s0_q !== 16'h0000) begin
            errors++; $display("FAIL shadow_next_sample: out %h s0 %h want 0000 0000", oOut, dut.s0_q);
        end
        do_reset();
        tick(1'b0, 16'h0, 1'b1, 2'd3, 16'h0000, 1'b0);
        tick(1'b1, 16'h4000, 1'b0, 2'd0, 16'h0, 1'b0);
        idle(3);
        checks++; if (oOut !== 16'h0009) begin errors++; $display("FAIL shadow_addr3: got %h want 0009", oOut); end
    endtask

    task automatic test_overflow();
        logic [15:0] want2;
`ifdef LPF_SEQ_SATURATE_EN
        want2 = 16'h8000;
`else
        want2 = 16'h8003;
`endif
        do_reset();
        tick(1'b0, 16'h0, 1'b1, 2'd0, 16'h8000, 1'b0);
        tick(1'b1, 16'h7fff, 1'b0, 2'd0, 16'h0, 1'b0);
        idle(3);
        checks++; if (dut.s0_q !== 16'h8001) begin errors++; $display("FAIL overflow_first_s0: got %h want 8001", dut.s0_q); end
        tick(1'b1, 16'h7fff, 1'b0, 2'd0, 16'h0, 1'b0);
        idle(3);
        checks++; if (dut.s0_q !== want2) begin errors++; $display("FAIL overflow_second_s0: got %h want %h", dut.s0_q, want2); end
        checks++; if (int'($signed(oOut)) !== m_out) begin
            errors++; $display("FAIL overflow_out: got %0d want %0d", $signed(oOut), m_out);
        end
    endtask

    task automatic test_reset_mid();
        int nvalid;
        do_reset();
        tick(1'b0, 16'h0, 1'b1, 2'd0, 16'h0000, 1'b0);
        tick(1'b1, 16'h4000, 1'b0, 2'd0, 16'h0, 1'b0);
        idle(1);
        rstn = 1'b0;
        idle(1);
        checks++; if (oBusy !== 1'b0 || oOut !== 16'h0000) begin
            errors++; $display("FAIL midreset_state: busy %b out %h want 0 0000", oBusy, oOut);
        end
        rstn = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            nvalid += int'(oValid);
        end
        checks++; if (nvalid !== 0) begin errors++; $display("FAIL midreset_valid: got %0d pulses want 0", nvalid); end
        tick(1'b1, 16'h4000, 1'b0, 2'd0, 16'h0, 1'b0);
        idle(3);
        checks++; if (oOut !== 16'h0009) begin errors++; $display("FAIL midreset_coef_restored: got %h want 0009", oOut); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick(1'b1, 16'($urandom), 1'b0, 2'd0, 16'h0, 1'b0);
        idle(3);
        checks++; if (oValid !== 1'b1 || int'($signed(oOut)) !== m_out) begin
            errors++; $display("FAIL b2b_first: valid %b out %0d want 1 %0d", oValid, $signed(oOut), m_out);
        end
        tick(1'b1, 16'($urandom), 1'b0, 2'd0, 16'h0, 1'b0);
        checks++; if (oValid !== 1'b0 || oBusy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: valid %b busy %b want 0 1", oValid, oBusy);
        end
        idle(3);
        checks++; if (oValid !== 1'b1 || int'($signed(oOut)) !== m_out) begin
            errors++; $display("FAIL b2b_second: valid %b out %0d want 1 %0d", oValid, $signed(oOut), m_out);
        end
        checks++; if (oOverrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b want 0", oOverrun); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom % 3) == 0, 16'($urandom), ($urandom % 8) == 0,
                 2'($urandom), 16'($urandom), ($urandom % 16) == 0);
            checks++;
            if (oValid !== m_valid || oBusy !== m_busy || oOverrun !== m_ovr
                || int'($signed(oOut)) !== m_out) begin
                errors++;
                if (errors < 20)
                    $display("FAIL random_cycle %0d: valid %b busy %b ovr %b out %0d want %b %b %b %0d",
                             i, oValid, oBusy, oOverrun, $signed(oOut), m_valid, m_busy, m_ovr, m_out);
            end
        end
    endtask

    initial begin
        m_edge = 0;
        test_reset();
        test_step();
        test_overrun();
        test_shadow();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
